dcache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache that answers the MEM stage's Mcache request port (address/data/load/store/byte-select in; result and stall out). It refills 4-word lines over a single-word request/acknowledge memory bus. Memory errors are reported to the MEM stage as a one-cycle BUS_ERROR_SX pulse. It sits between the MEM stage and the external memory arbiter.

---
 rtl/dcache.sv | 190 +++++++++++++++++++
 tb/tb_dcache.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache.sv
// dcache: direct-mapped write-through, no-write-allocate cache; 4-word refill over a request/ack bus.
// Load hits complete with no wait state. DCACHE_WBUF_EN adds a one-entry background store buffer.
module dcache #(
    parameter int NB_LINES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] MCACHE_ADR_SM,
    input  logic [31:0] MCACHE_DATA_SM,
    input  logic        MCACHE_ADR_VALID_SM,
    input  logic        MCACHE_LOAD_SM,
    input  logic        MCACHE_STORE_SM,
    input  logic [3:0]  byt_sel,
    output logic [31:0] MCACHE_RESULT_SM,
    output logic        MCACHE_STALL_SM,
    output logic        BUS_ERROR_SX,
    input  logic        DCACHE_FLUSH,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADR,
    output logic [31:0] MEM_WDATA,
    output logic [3:0]  MEM_BE,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ACK,
    input  logic        MEM_ERR
);
    localparam int IW = $clog2(NB_LINES);
    localparam int TW = 28 - IW;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;
    state_t state_q, state_d;

    logic [31:0]         data_q [NB_LINES][4];
    logic [TW-1:0]       tag_q  [NB_LINES];
    logic [NB_LINES-1:0] valid_q, valid_d;

    logic [TW-1:0] rtag_q, rtag_d;
    logic [IW-1:0] ridx_q, ridx_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          flush_q, flush_d;
    logic [31:0]   wadr_q, wadr_d, wdat_q, wdat_d;
    logic [3:0]    wbe_q, wbe_d;
    logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0]   mem_adr_q, mem_adr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;

    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_idx;
    logic [1:0]    req_word;
    logic          req_ld, req_st, hit, ack_ok, ack_err, refill_we, merge_we;
    logic [31:0]   st_lanes;

    assign req_tag  = MCACHE_ADR_SM[31:4+IW];
    assign req_idx  = MCACHE_ADR_SM[3+IW:4];
    assign req_word = MCACHE_ADR_SM[3:2];
    assign req_ld   = MCACHE_ADR_VALID_SM && (byt_sel != 4'b0000) && MCACHE_LOAD_SM;
    assign req_st   = MCACHE_ADR_VALID_SM && (byt_sel != 4'b0000) && MCACHE_STORE_SM;
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign ack_ok   = mem_req_q && MEM_ACK && !MEM_ERR;
    assign ack_err  = mem_req_q && MEM_ACK && MEM_ERR;
    assign st_lanes = (MCACHE_DATA_SM << {MCACHE_ADR_SM[1:0], 3'b000})
                    & {{8{byt_sel[3]}}, {8{byt_sel[2]}}, {8{byt_sel[1]}}, {8{byt_sel[0]}}};

    assign MEM_REQ   = mem_req_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_ADR   = mem_adr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign MEM_BE    = mem_be_q;

    always_comb begin
        state_d = state_q;   valid_d = valid_q;   rtag_d = rtag_q;   ridx_d = ridx_q;
        cnt_d = cnt_q;       flush_d = flush_q | DCACHE_FLUSH;
        wadr_d = wadr_q;     wdat_d = wdat_q;     wbe_d = wbe_q;
        mem_req_d = mem_req_q;   mem_we_d = mem_we_q;   mem_adr_d = mem_adr_q;
        mem_wdata_d = mem_wdata_q;   mem_be_d = mem_be_q;
        MCACHE_STALL_SM = 1'b0;  MCACHE_RESULT_SM = 32'h0;  BUS_ERROR_SX = 1'b0;
        refill_we = 1'b0;        merge_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_q || DCACHE_FLUSH) begin
                    MCACHE_STALL_SM = 1'b1;
                    valid_d = '0;
                    flush_d = 1'b0;
                end else if (req_ld && hit) begin
                    MCACHE_RESULT_SM = data_q[req_idx][req_word];
                end else if (req_ld) begin
                    MCACHE_STALL_SM = 1'b1;
                    rtag_d = req_tag;
                    ridx_d = req_idx;
                    valid_d[req_idx] = 1'b0;
                    cnt_d = 2'd0;
                    state_d = REFILL;
                end else if (req_st) begin
                    merge_we = hit;
                    wadr_d = {MCACHE_ADR_SM[31:2], 2'b00};
                    wdat_d = st_lanes;
                    wbe_d = byt_sel;
                    state_d = WRITE;
`ifdef DCACHE_WBUF_EN
                    MCACHE_STALL_SM = 1'b0;
`else
                    MCACHE_STALL_SM = 1'b1;
`endif
                end
            end
            REFILL: begin
                MCACHE_STALL_SM = 1'b1;
                if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                    mem_we_d = 1'b0;
                    mem_adr_d = {rtag_q, ridx_q, cnt_q, 2'b00};
                    mem_be_d = 4'hF;
                end else if (ack_err) begin
                    mem_req_d = 1'b0;
                    MCACHE_STALL_SM = 1'b0;
                    BUS_ERROR_SX = 1'b1;
                    state_d = IDLE;
                end else if (ack_ok) begin
                    mem_req_d = 1'b0;
                    refill_we = 1'b1;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        valid_d[ridx_q] = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
`ifdef DCACHE_WBUF_EN
                // The buffered store already retired; keep serving hits while it drains.
                if (req_ld && hit) MCACHE_RESULT_SM = data_q[req_idx][req_word];
                else               MCACHE_STALL_SM = req_ld || req_st;
`else
                MCACHE_STALL_SM = 1'b1;
`endif
                if (!mem_req_q) begin
                    mem_req_d = 1'b1;
                    mem_we_d = 1'b1;
                    mem_adr_d = wadr_q;
                    mem_wdata_d = wdat_q;
                    mem_be_d = wbe_q;
                end else if (ack_err) begin
                    mem_req_d = 1'b0;
                    BUS_ERROR_SX = 1'b1;
                    state_d = IDLE;
`ifndef DCACHE_WBUF_EN
                    MCACHE_STALL_SM = 1'b0;
`endif
                end else if (ack_ok) begin
                    mem_req_d = 1'b0;
`ifdef DCACHE_WBUF_EN
                    state_d = IDLE;
`else
                    state_d = DONE;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;     valid_q <= '0;      rtag_q <= '0;    ridx_q <= '0;
            cnt_q <= 2'd0;       flush_q <= 1'b0;    wadr_q <= '0;    wdat_q <= '0;
            wbe_q <= 4'h0;       mem_req_q <= 1'b0;  mem_we_q <= 1'b0;
            mem_adr_q <= '0;     mem_wdata_q <= '0;  mem_be_q <= 4'h0;
        end else begin
            state_q <= state_d;  valid_q <= valid_d; rtag_q <= rtag_d; ridx_q <= ridx_d;
            cnt_q <= cnt_d;      flush_q <= flush_d; wadr_q <= wadr_d; wdat_q <= wdat_d;
            wbe_q <= wbe_d;      mem_req_q <= mem_req_d;  mem_we_q <= mem_we_d;
            mem_adr_q <= mem_adr_d;  mem_wdata_q <= mem_wdata_d;  mem_be_q <= mem_be_d;
        end
    end

    // Arrays need no reset: the valid bits alone decide whether their contents are used.
    always_ff @(posedge clk) begin
        if (refill_we) begin
            data_q[ridx_q][cnt_q] <= MEM_RDATA;
            tag_q[ridx_q] <= rtag_q;
        end
        if (merge_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byt_sel[b]) data_q[req_idx][req_word][8*b +: 8] <= st_lanes[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: stimulus queues expected responses and bus beats, monitors pop and compare.
module tb_dcache;
    logic        clk, reset_n;
    logic [31:0] MCACHE_ADR_SM, MCACHE_DATA_SM, MCACHE_RESULT_SM;
    logic        MCACHE_ADR_VALID_SM, MCACHE_LOAD_SM, MCACHE_STORE_SM;
    logic [3:0]  byt_sel, MEM_BE;
    logic        MCACHE_STALL_SM, BUS_ERROR_SX, DCACHE_FLUSH;
    logic        MEM_REQ, MEM_WE, MEM_ACK, MEM_ERR;
    logic [31:0] MEM_ADR, MEM_WDATA, MEM_RDATA;

    dcache #(.NB_LINES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .MCACHE_ADR_SM(MCACHE_ADR_SM), .MCACHE_DATA_SM(MCACHE_DATA_SM),
        .MCACHE_ADR_VALID_SM(MCACHE_ADR_VALID_SM), .MCACHE_LOAD_SM(MCACHE_LOAD_SM),
        .MCACHE_STORE_SM(MCACHE_STORE_SM), .byt_sel(byt_sel),
        .MCACHE_RESULT_SM(MCACHE_RESULT_SM), .MCACHE_STALL_SM(MCACHE_STALL_SM),
        .BUS_ERROR_SX(BUS_ERROR_SX), .DCACHE_FLUSH(DCACHE_FLUSH),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADR(MEM_ADR), .MEM_WDATA(MEM_WDATA),
        .MEM_BE(MEM_BE), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .MEM_ERR(MEM_ERR)
    );

    typedef struct packed {logic [31:0] res; logic err;} rsp_t;
    typedef struct packed {logic we; logic [31:0] adr; logic [31:0] wd; logic [3:0] be;} bus_t;

`ifdef DCACHE_WBUF_EN
    localparam int ST_STALL = 0;
`else
    localparam int ST_STALL = 3;
`endif

    int          n_vec = 0;
    int          n_bad = 0;
    int          err_at = -1;
    int          ack_n = 0;
    rsp_t        rsp_q[$];
    bus_t        bus_q[$];
    logic [31:0] mem [0:4095];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory: acknowledges in the first cycle MEM_REQ is seen high; err_at selects an erroring beat.
    initial begin
        MEM_ACK = 1'b0; MEM_ERR = 1'b0; MEM_RDATA = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n || MEM_ACK || !MEM_REQ) begin
                MEM_ACK = 1'b0; MEM_ERR = 1'b0;
            end else begin
                ack_n++;
                MEM_ACK = 1'b1;
                MEM_ERR = (ack_n == err_at);
                if (MEM_WE && !MEM_ERR) begin
                    for (int b = 0; b < 4; b++)
                        if (MEM_BE[b]) mem[MEM_ADR[13:2]][8*b +: 8] = MEM_WDATA[8*b +: 8];
                end
                MEM_RDATA = MEM_ERR ? 32'h0 : mem[MEM_ADR[13:2]];
            end
        end
    end

    initial begin
        rsp_t er;
        bus_t eb;
        forever begin
            @(negedge clk);
            if (reset_n && MCACHE_ADR_VALID_SM && (MCACHE_LOAD_SM || MCACHE_STORE_SM)
                && byt_sel != 4'h0 && !MCACHE_STALL_SM) begin
                if (rsp_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL rsp_unexpected: got result %h with no response expected", MCACHE_RESULT_SM);
                end else begin
                    er = rsp_q.pop_front();
                    chk("rsp_result", MCACHE_RESULT_SM, er.res);
                    chk("rsp_buserr", 32'(BUS_ERROR_SX), 32'(er.err));
                end
            end
            if (reset_n && MEM_REQ && MEM_ACK) begin
                if (bus_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL bus_unexpected: got beat at %h with none expected", MEM_ADR);
                end else begin
                    eb = bus_q.pop_front();
                    chk("bus_we", 32'(MEM_WE), 32'(eb.we));
                    chk("bus_adr", MEM_ADR, eb.adr);
                    chk("bus_be", 32'(MEM_BE), 32'(eb.be));
                    if (eb.we) chk("bus_wdata", MEM_WDATA, eb.wd);
                end
            end
        end
    end

    task automatic exp_line(input logic [31:0] base, input int beats);
        for (int i = 0; i < beats; i++) bus_q.push_back({1'b0, base + 32'(4 * i), 32'h0, 4'hF});
    endtask

    task automatic exp_write(input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] be);
        bus_q.push_back({1'b1, adr, wd, be});
    endtask

    // Presents a request from posedge+1 until it retires, checking the stall-cycle count.
    task automatic access(input string nm, input logic [31:0] adr, input logic [31:0] dat, input bit st,
                          input logic [3:0] be, input logic [31:0] res, input bit err, input int stalls);
        int n;
        rsp_q.push_back({res, err});
        MCACHE_ADR_SM = adr; MCACHE_DATA_SM = dat; byt_sel = be;
        MCACHE_LOAD_SM = !st; MCACHE_STORE_SM = st; MCACHE_ADR_VALID_SM = 1'b1;
        n = 0;
        @(negedge clk);
        while (MCACHE_STALL_SM && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk(nm, 32'(n), 32'(stalls));
        @(posedge clk); #1;
    endtask

    task automatic idle(input int cycles);
        MCACHE_ADR_VALID_SM = 1'b0; MCACHE_LOAD_SM = 1'b0; MCACHE_STORE_SM = 1'b0; byt_sel = 4'h0;
        repeat (cycles) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hD000_0000 | 32'(i);
        mem[12'h040] = 32'h11; mem[12'h041] = 32'h22; mem[12'h042] = 32'h33; mem[12'h043] = 32'h44;
        mem[12'h0C0] = 32'hA0; mem[12'h0C1] = 32'hA1; mem[12'h0C2] = 32'hA2; mem[12'h0C3] = 32'hA3;
        reset_n = 1'b0; DCACHE_FLUSH = 1'b0;
        MCACHE_ADR_SM = 32'h0; MCACHE_DATA_SM = 32'h0;
        MCACHE_ADR_VALID_SM = 1'b0; MCACHE_LOAD_SM = 1'b0; MCACHE_STORE_SM = 1'b0; byt_sel = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(MEM_REQ), 32'h0);
        chk("rst_we", 32'(MEM_WE), 32'h0);
        chk("rst_adr", MEM_ADR, 32'h0);
        chk("rst_wdata", MEM_WDATA, 32'h0);
        chk("rst_be", 32'(MEM_BE), 32'h0);
        chk("rst_stall", 32'(MCACHE_STALL_SM), 32'h0);
        chk("rst_buserr", 32'(BUS_ERROR_SX), 32'h0);
        chk("rst_result", MCACHE_RESULT_SM, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        exp_line(32'h100, 4);
        access("stall_cold_miss", 32'h100, 32'h0, 1'b0, 4'hF, 32'h11, 1'b0, 9);
        access("stall_hit_104", 32'h104, 32'h0, 1'b0, 4'hF, 32'h22, 1'b0, 0);
        exp_write(32'h104, 32'h0000AB00, 4'b0010);
        access("stall_store_hit", 32'h105, 32'h000000AB, 1'b1, 4'b0010, 32'h0, 1'b0, ST_STALL);
        idle(4);
        access("stall_hit_merged", 32'h104, 32'h0, 1'b0, 4'hF, 32'h0000AB22, 1'b0, 0);
        exp_write(32'h2000, 32'hCAFEF00D, 4'hF);
        access("stall_store_miss", 32'h2000, 32'hCAFEF00D, 1'b1, 4'hF, 32'h0, 1'b0, ST_STALL);
        idle(4);
        exp_line(32'h2000, 4);
        access("stall_miss_2000", 32'h2000, 32'h0, 1'b0, 4'hF, 32'hCAFEF00D, 1'b0, 9);
        exp_line(32'h100, 4);
        access("stall_conflict_108", 32'h108, 32'h0, 1'b0, 4'hF, 32'h33, 1'b0, 9);

        err_at = ack_n + 3;
        exp_line(32'h300, 3);
        access("stall_err_beat3", 32'h300, 32'h0, 1'b0, 4'hF, 32'h0, 1'b1, 6);
        idle(1);
        exp_line(32'h300, 4);
        access("stall_reload_300", 32'h300, 32'h0, 1'b0, 4'hF, 32'hA0, 1'b0, 9);

        // Reset lands while the second refill beat is on the bus.
        exp_line(32'h100, 1);
        MCACHE_ADR_SM = 32'h100; byt_sel = 4'hF; MCACHE_LOAD_SM = 1'b1; MCACHE_ADR_VALID_SM = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(MEM_REQ && MEM_ACK) && n < 20) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("req_beat2_up", 32'(MEM_REQ), 32'h1);
        reset_n = 1'b0;
        MCACHE_ADR_VALID_SM = 1'b0; MCACHE_LOAD_SM = 1'b0; byt_sel = 4'h0;
        #1;
        chk("req_async_rst", 32'(MEM_REQ), 32'h0);
        chk("stall_async_rst", 32'(MCACHE_STALL_SM), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        exp_line(32'h300, 4);
        access("stall_miss_after_rst", 32'h300, 32'h0, 1'b0, 4'hF, 32'hA0, 1'b0, 9);
        access("stall_hit_304", 32'h304, 32'h0, 1'b0, 4'hF, 32'hA1, 1'b0, 0);

        idle(0);
        DCACHE_FLUSH = 1'b1;
        @(negedge clk);
        chk("stall_flush", 32'(MCACHE_STALL_SM), 32'h1);
        @(posedge clk); #1;
        DCACHE_FLUSH = 1'b0;
        exp_line(32'h300, 4);
        access("stall_miss_after_flush", 32'h304, 32'h0, 1'b0, 4'hF, 32'hA1, 1'b0, 9);

        MCACHE_ADR_SM = 32'h500; byt_sel = 4'h0; MCACHE_LOAD_SM = 1'b1; MCACHE_ADR_VALID_SM = 1'b1;
        @(negedge clk);
        chk("bytsel0_stall", 32'(MCACHE_STALL_SM), 32'h0);
        chk("bytsel0_result", MCACHE_RESULT_SM, 32'h0);
        repeat (3) @(negedge clk);
        chk("bytsel0_no_req", 32'(MEM_REQ), 32'h0);
        @(posedge clk); #1;
        idle(1);

`ifdef DCACHE_WBUF_EN
        exp_write(32'h600, 32'h01020304, 4'hF);
        exp_write(32'h604, 32'h05060708, 4'hF);
        access("stall_wbuf_st1", 32'h600, 32'h01020304, 1'b1, 4'hF, 32'h0, 1'b0, 0);
        access("stall_wbuf_st2", 32'h604, 32'h05060708, 1'b1, 4'hF, 32'h0, 1'b0, 2);
        idle(4);
`endif

        idle(2);
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'h0);
        chk("bus_q_drained", 32'(bus_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
